// File: rtl/main_memory.sv
// Block-granular backing memory for the data cache: 64 x 128-bit blocks with a fixed
// access latency, one request at a time, plus saturating read/write access counters.
module main_memory #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             readWrite,
    input  logic [9:0]       addr,
    input  logic [127:0]     writeDataMem,
    output logic             ready,
    output logic             ack,
    output logic [127:0]     readDataMem,
    output logic [CNT_W-1:0] readCount,
    output logic [CNT_W-1:0] writeCount
);

    localparam int unsigned BLOCKS = 64;
    localparam int unsigned BLK_W  = 6;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned LAT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic               accept;
    logic               perform;
    logic [LAT_W-1:0]   cnt;
    logic               latRw;
    logic [BLK_W-1:0]   latBlk;
    logic [DATA_W-1:0]  latData;

    // Blocks are stored XORed with their power-on pattern, so an all-zero array reads
    // back as the initial contents (each word holds its own word address).
    logic [DATA_W-1:0]  memDelta [BLOCKS] = '{default: '0};

    logic unusedAddrBits;
    assign unusedAddrBits = ^addr[3:0];

    function automatic logic [DATA_W-1:0] initBlock(input logic [BLK_W-1:0] blk);
        initBlock = '0;
        for (int w = 0; w < 4; w++) begin
            initBlock[w*32 +: 32] = 32'({blk, 2'(w)});
        end
    endfunction

    assign ready = (state == IDLE);

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        perform   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    stateNext = BUSY;
                    accept    = 1'b1;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    stateNext = RESP;
                    perform   = 1'b1;
                end
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            ack         <= 1'b0;
            readDataMem <= '0;
            readCount   <= '0;
            writeCount  <= '0;
        end else begin
            state <= stateNext;
            ack   <= perform;
            if (accept) begin
                cnt <= LAT_W'(LATENCY - 1);
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - LAT_W'(1);
            end
            if (perform) begin
                if (latRw) begin
                    if (writeCount != '1) writeCount <= writeCount + CNT_W'(1);
                end else begin
                    readDataMem <= memDelta[latBlk] ^ initBlock(latBlk);
                    if (readCount != '1) readCount <= readCount + CNT_W'(1);
                end
            end
        end
    end

    // Request capture; inputs are free to change once the request is taken.
    always_ff @(posedge clk) begin
        if (accept) begin
            latRw   <= readWrite;
            latBlk  <= addr[9:4];
            latData <= writeDataMem;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && perform && latRw) begin
            memDelta[latBlk] <= latData ^ initBlock(latBlk);
        end
    end

endmodule

// File: tb/tb_main_memory.sv
// Randomized and directed bench for main_memory: two instances (LATENCY=4/CNT_W=16 and
// LATENCY=1/CNT_W=2) checked every cycle against an edge-counting behavioural model.
module tb_main_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   rst;
    logic [1:0]   req;
    logic [1:0]   rw;
    logic [9:0]   addr [2];
    logic [127:0] wd   [2];
    logic [1:0]   rdy;
    logic [1:0]   ack;
    logic [127:0] rdata [2];
    logic [15:0]  rcA, wcA;
    logic [1:0]   rcB, wcB;

    main_memory #(.LATENCY(4), .CNT_W(16)) dutA (
        .clk(clk), .reset(rst[0]), .req(req[0]), .readWrite(rw[0]), .addr(addr[0]),
        .writeDataMem(wd[0]), .ready(rdy[0]), .ack(ack[0]), .readDataMem(rdata[0]),
        .readCount(rcA), .writeCount(wcA)
    );

    main_memory #(.LATENCY(1), .CNT_W(2)) dutB (
        .clk(clk), .reset(rst[1]), .req(req[1]), .readWrite(rw[1]), .addr(addr[1]),
        .writeDataMem(wd[1]), .ready(rdy[1]), .ack(ack[1]), .readDataMem(rdata[1]),
        .readCount(rcB), .writeCount(wcB)
    );

    // Model: mE = edges since acceptance, -1 when idle.
    int           mE   [2];
    logic         mAck [2];
    logic [127:0] mRd  [2];
    int           mRc  [2];
    int           mWc  [2];
    logic [127:0] mMem [2][64];
    logic         pRw  [2];
    int           pBlk [2];
    logic [127:0] pData[2];
    int           lat  [2] = '{4, 1};
    int           cmax [2] = '{65535, 3};

    int passCnt = 0;
    int totalCnt = 0;
    int edgeNo = 0;

    function automatic logic [127:0] initPattern(input int b);
        return {32'(b*4 + 3), 32'(b*4 + 2), 32'(b*4 + 1), 32'(b*4)};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic modelStep(input int d);
        if (rst[d]) begin
            mE[d] = -1; mAck[d] = 1'b0; mRd[d] = '0; mRc[d] = 0; mWc[d] = 0;
        end else if (mE[d] < 0) begin
            mAck[d] = 1'b0;
            if (req[d]) begin
                mE[d] = 0; pRw[d] = rw[d]; pBlk[d] = int'(addr[d][9:4]); pData[d] = wd[d];
            end
        end else begin
            mE[d]++;
            if (mE[d] == lat[d]) begin
                mAck[d] = 1'b1;
                if (pRw[d]) begin
                    mMem[d][pBlk[d]] = pData[d];
                    if (mWc[d] < cmax[d]) mWc[d]++;
                end else begin
                    mRd[d] = mMem[d][pBlk[d]];
                    if (mRc[d] < cmax[d]) mRc[d]++;
                end
            end else if (mE[d] > lat[d]) begin
                mE[d] = -1; mAck[d] = 1'b0;
            end
        end
    endtask

    // One clock: advance the model for the edge just taken, then compare all outputs.
    task automatic tick();
        @(negedge clk);
        edgeNo++;
        for (int d = 0; d < 2; d++) begin
            modelStep(d);
            chk($sformatf("ready%0d", d), 128'(rdy[d]), 128'(mE[d] < 0));
            chk($sformatf("ack%0d", d), 128'(ack[d]), 128'(mAck[d]));
            chk($sformatf("readData%0d", d), rdata[d], mRd[d]);
            chk($sformatf("readCount%0d", d), d == 0 ? 128'(rcA) : 128'(rcB), 128'(mRc[d]));
            chk($sformatf("writeCount%0d", d), d == 0 ? 128'(wcA) : 128'(wcB), 128'(mWc[d]));
            chk($sformatf("readyAckExcl%0d", d), 128'(rdy[d] & ack[d]), 128'(0));
        end
    endtask

    task automatic request(input int d, input logic w, input logic [9:0] a,
                           input logic [127:0] data, output int accE, output int ackE);
        logic wasReady;
        req[d] = 1'b1; rw[d] = w; addr[d] = a; wd[d] = data;
        accE = -1; ackE = -1;
        for (int i = 0; i < 40 && accE < 0; i++) begin
            wasReady = rdy[d];
            tick();
            if (wasReady) accE = edgeNo;
        end
        req[d] = 1'b0;
        for (int i = 0; i < 40 && ackE < 0 && accE >= 0; i++) begin
            tick();
            if (ack[d]) ackE = edgeNo;
        end
        if (accE < 0 || ackE < 0) chk("requestTimeout", 128'(0), 128'(1));
    endtask

    task automatic doReset(input logic [1:0] which);
        rst = which;
        tick();
        rst = 2'b00;
    endtask

    localparam logic [127:0] WDATA = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_0123;

    initial begin
        int a, k, n, m;
        int accs [4];
        int acks [4];
        logic wasReady, sawAck;
        logic [9:0] alt [2];

        rst = 2'b11; req = '0; rw = '0;
        addr = '{default: '0}; wd = '{default: '0};
        for (int d = 0; d < 2; d++) begin
            mE[d] = -1; mAck[d] = 1'b0; mRd[d] = '0; mRc[d] = 0; mWc[d] = 0;
            for (int b = 0; b < 64; b++) mMem[d][b] = initPattern(b);
        end
        tick();
        tick();
        rst = 2'b00;

        // Read of block 5 after reset.
        request(0, 1'b0, 10'h050, '0, a, k);
        chk("t1Latency", 128'(k - a), 128'(4));
        chk("t1Data", rdata[0], {32'd23, 32'd22, 32'd21, 32'd20});
        chk("t1ReadCount", 128'(rcA), 128'(1));
        tick();
        chk("t1AckOneCycle", 128'(ack[0]), 128'(0));

        // Write block 3 then read it back through a different low-nibble address.
        doReset(2'b01);
        request(0, 1'b1, 10'h030, WDATA, a, k);
        request(0, 1'b0, 10'h03C, '0, a, k);
        chk("t2Data", rdata[0], WDATA);
        chk("t2WriteCount", 128'(wcA), 128'(1));
        chk("t2ReadCount", 128'(rcA), 128'(1));
        tick();

        // req held high, alternating blocks, inputs scrambled while busy.
        alt[0] = 10'h100; alt[1] = 10'h2A0;
        n = 0; m = 0;
        req[0] = 1'b1;
        for (int i = 0; i < 80 && n < 4; i++) begin
            wasReady = rdy[0];
            if (wasReady) begin
                addr[0] = alt[n % 2]; rw[0] = 1'b0;
            end else begin
                addr[0] = 10'($urandom_range(0, 1023));
                wd[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
                rw[0] = 1'($urandom_range(0, 1));
            end
            tick();
            if (wasReady) begin accs[n] = edgeNo; n++; end
            if (ack[0] && m < 4) begin acks[m] = edgeNo; m++; end
        end
        req[0] = 1'b0;
        if (n < 4 || m < 3) chk("t3Timeout", 128'(0), 128'(1));
        else for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3Spacing%0d", i), 128'(accs[i+1] - accs[i]), 128'(6));
            chk($sformatf("t3AckToAccept%0d", i), 128'(accs[i+1] - acks[i]), 128'(2));
        end
        for (int i = 0; i < 8; i++) tick();

        // Write to block 7 aborted by reset two edges after acceptance.
        doReset(2'b01);
        request(0, 1'b1, 10'h070, WDATA, a, k);
        chk("t4PreWriteCount", 128'(wcA), 128'(1));
        req[0] = 1'b1; rw[0] = 1'b1; addr[0] = 10'h070; wd[0] = ~WDATA;
        a = -1;
        for (int i = 0; i < 20 && a < 0; i++) begin
            wasReady = rdy[0];
            tick();
            if (wasReady) a = edgeNo;
        end
        req[0] = 1'b0;
        tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        sawAck = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ack[0]) sawAck = 1'b1;
        end
        chk("t4NoAck", 128'(sawAck), 128'(0));
        chk("t4WriteCount", 128'(wcA), 128'(0));
        request(0, 1'b0, 10'h074, '0, a, k);
        chk("t4KeptEarlierWrite", rdata[0], WDATA);
        doReset(2'b01);
        request(0, 1'b0, 10'h1C4, '0, a, k);
        chk("t4Block28", rdata[0], {32'd115, 32'd114, 32'd113, 32'd112});

        // LATENCY=1 instance: five reads, counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            request(1, 1'b0, 10'($urandom_range(0, 1023)), '0, a, k);
            chk($sformatf("t5Latency%0d", i), 128'(k - a), 128'(1));
            chk($sformatf("t5ReadCount%0d", i), 128'(rcB), 128'(i < 3 ? i + 1 : 3));
        end
        request(1, 1'b0, 10'h07F, '0, a, k);
        chk("t5Block7", rdata[1], {32'd31, 32'd30, 32'd29, 32'd28});

        // Fully random traffic on both instances, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            for (int d = 0; d < 2; d++) begin
                rst[d]  = ($urandom_range(0, 59) == 0);
                req[d]  = ($urandom_range(0, 9) < 6);
                rw[d]   = 1'($urandom_range(0, 1));
                addr[d] = 10'($urandom_range(0, 1023));
                wd[d]   = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            tick();
        end
        rst = 2'b00; req = 2'b00;
        for (int i = 0; i < 10; i++) tick();

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/main_memory.md
# main_memory

Block-granular main memory that sits directly downstream of the 2-way set-associative data cache and services its miss refills and dirty write-backs. It stores 1 KiB as 64 blocks of 128 bits, accepts one block request at a time over a req/ready handshake, and completes each access after a fixed, parameterised latency. It also keeps saturating read/write access counters for miss-traffic measurement.

## Interface
- `LATENCY`, 4: cycles from request acceptance to completion; legal range 1..15.
- `CNT_W`, 16: width of the access counters.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req`  in  1: request valid from the cache.
- `readWrite`  in  1: 0 = read block, 1 = write block.
- `addr`  in  10: byte address; `addr[9:4]` selects the block; `addr[3:0]` is ignored.
- `writeDataMem`  in  128: block to store; word 0 in `[31:0]`, word 3 in `[127:96]`.
- `ready`  out  1: high exactly when the block is idle and can accept a request.
- `ack`  out  1: one-cycle completion pulse.
- `readDataMem`  out  128: block returned by the last completed read; same word order as `writeDataMem`.
- `readCount`  out  CNT_W: number of completed reads, saturating.
- `writeCount`  out  CNT_W: number of completed writes, saturating.

## Operation
- Storage: 64 x 128-bit array. Initial contents: each 32-bit word holds its own word address `addr[9:2]`, zero-extended. For example, block 5 = {32'd23, 32'd22, 32'd21, 32'd20}.
- Reset clears only the FSM, counters and outputs. It never clears the array.
- FSM states: IDLE, BUSY, RESP.
- IDLE: `ready` = 1. If `req` is high at an edge, the request is accepted. The block latches `readWrite`, `addr[9:4]` and `writeDataMem`, loads `cnt` with LATENCY-1, and moves to BUSY.
- BUSY: `ready` = 0. Changes on the inputs are ignored because the latched copies are used.
  - At each edge with `cnt` != 0, `cnt` decrements.
  - At the edge with `cnt` == 0, the access is performed and the FSM moves to RESP:
    - Write: array[block] <= latched data.
    - Read: `readDataMem` <= array[block].
  - At that same edge, `ack` <= 1 and the matching counter increments. A counter at all-ones holds its value.
- RESP: `ack` = 1 and `ready` = 0. At the next edge the FSM unconditionally returns to IDLE and `ack` <= 0.
- `req` asserted while `ready` is low is ignored. The requester must hold `req`, `readWrite`, `addr` and `writeDataMem` stable until it samples `ready` high at an edge.
- A read of a block that was just written returns the new data. Accesses are strictly sequential, so no hazard exists.
- `readDataMem` holds its value until the next read completes. Writes do not change it.

## Timing
- Reset values: state = IDLE, `ready` = 1 (combinational from state), `ack` = 0, `readDataMem` = 0, `readCount` = 0, `writeCount` = 0, `cnt` = 0.
- Reset has priority over all other activity. If reset is asserted in BUSY or RESP, the in-flight access is dropped: no array write, no `ack`, no counter change. `ready` is 1 in the cycle after the reset edge.
- With the acceptance edge called E0, the access is performed at edge E(LATENCY). `ack` and the new `readDataMem` are visible during the cycle after E(LATENCY).
- The FSM returns to IDLE at E(LATENCY+1). The earliest next acceptance is E(LATENCY+2), so back-to-back requests have a period of LATENCY+2 cycles.
- LATENCY = 1 is legal: accept at E0, perform at E1, `ack` high during the cycle after E1.
- `ready` is never high in the same cycle as `ack`.

## Test plan
- Reset, then read `addr` = 10'h050 with LATENCY = 4 → `ack` high exactly one cycle, after the 4th edge following acceptance. `readDataMem` = {32'd23, 32'd22, 32'd21, 32'd20}. `readCount` = 1.
- Write block 3 with 128'hDEAD_BEEF_..._0123, then read `addr` = 10'h03C → the returned block equals the written data. `addr[3:0]` is ignored. `writeCount` = 1, `readCount` = 1.
- Hold `req` high continuously while alternating reads of two blocks → acceptances are spaced exactly LATENCY+2 edges apart. Changing `addr` and `writeDataMem` mid-BUSY has no effect.
- Write to block 7, then assert reset two edges after acceptance → no `ack`, `writeCount` = 0. A subsequent read of block 7 returns the initial pattern {32'd31, 32'd30, 32'd29, 32'd28}.
- Build with LATENCY = 1 and CNT_W = 2, then issue 5 reads → each `ack` arrives 1 edge after its acceptance, and `readCount` saturates at 3.
- Assert `req` during RESP → the request is not accepted until the IDLE cycle. `ready` and `ack` are never high together.
